// File: rtl/rshift_seq.sv
// rshift_seq: sequential right shifter, one bit position per clock.
// Modes: 00 logical, 01 arithmetic (sign fill), 10 rotate right, 11 logical.
// Ports:
//   clk   - rising-edge clock
//   rst   - synchronous active-high reset
//   start - request, sampled only while idle
//   A     - operand, captured on the accepting edge
//   shr   - shift amount, captured on the accepting edge
//   mode  - shift mode, captured on the accepting edge
//   busy  - high whenever the FSM is not idle
//   done  - one-cycle strobe, OUT holds the result while high
//   OUT   - shift register contents, holds the last result
module rshift_seq #(
   parameter int unsigned WIDTH = 4,
   parameter int unsigned SHW   = 2
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] A,
   input  logic [SHW-1:0]   shr,
   input  logic [1:0]       mode,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] OUT
);

   localparam logic [1:0] MODE_ARITH  = 2'b01;
   localparam logic [1:0] MODE_ROTATE = 2'b10;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } state_e;

   state_e           state_q, state_d;
   logic [WIDTH-1:0] sreg_q, sreg_d;
   logic [SHW-1:0]   cnt_q, cnt_d;
   logic [1:0]       mreg_q, mreg_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;
   logic             fill_bit;

   // Bit entering at the MSB on each shift step.
   always_comb begin
      fill_bit = 1'b0;
      if (mreg_q == MODE_ARITH) begin
         fill_bit = sreg_q[WIDTH-1];
      end else if (mreg_q == MODE_ROTATE) begin
         fill_bit = sreg_q[0];
      end
   end

   // Next-state and datapath update.
   always_comb begin
      state_d = state_q;
      sreg_d  = sreg_q;
      cnt_d   = cnt_q;
      mreg_d  = mreg_q;
      unique case (state_q)
         IDLE: begin
            if (start) begin
               sreg_d  = A;
               cnt_d   = shr;
               mreg_d  = mode;
               state_d = SHIFT;
            end
         end
         SHIFT: begin
            if (cnt_q != '0) begin
               sreg_d = {fill_bit, sreg_q[WIDTH-1:1]};
               cnt_d  = cnt_q - SHW'(1);
            end else begin
               state_d = DONE;
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
      // Status flags are registered from the next state so they align with it.
      busy_d = (state_d != IDLE);
      done_d = (state_d == DONE);
   end

   // State and output registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         sreg_q  <= '0;
         cnt_q   <= '0;
         mreg_q  <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         sreg_q  <= sreg_d;
         cnt_q   <= cnt_d;
         mreg_q  <= mreg_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
      end
   end

   assign busy = busy_q;
   assign done = done_q;
   assign OUT  = sreg_q;

endmodule

// File: tb/tb_rshift_seq.sv
// tb_rshift_seq: directed table-driven bench for rshift_seq at default widths.
module tb_rshift_seq;

   logic       clk;
   logic       rst;
   logic       start;
   logic [3:0] A;
   logic [1:0] shr;
   logic [1:0] mode;
   logic       busy;
   logic       done;
   logic [3:0] OUT;

   int checks;
   int errors;

   rshift_seq #(.WIDTH(4), .SHW(2)) dut (
      .clk  (clk),
      .rst  (rst),
      .start(start),
      .A    (A),
      .shr  (shr),
      .mode (mode),
      .busy (busy),
      .done (done),
      .OUT  (OUT)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [3:0] a;
      logic [1:0] s;
      logic [1:0] m;
      logic [3:0] exp_out;
      int         exp_lat;
   } vec_t;

   vec_t vecs[7];

   task automatic chk(input string name, input int act, input int expv);
      checks++;
      if (act != expv) begin
         errors++;
         $display("FAIL %s got %0h expected %0h", name, act, expv);
      end
   endtask

   // Advance one clock; inputs change and outputs are sampled at negedge.
   task automatic cyc();
      @(posedge clk);
      @(negedge clk);
   endtask

   // Issue one operation and check latency, result and return to idle.
   task automatic run_op(input logic [3:0] a, input logic [1:0] s,
                         input logic [1:0] m, input logic [3:0] exp_out,
                         input int exp_lat, input string name);
      int n;
      start = 1'b1; A = a; shr = s; mode = m;
      cyc();
      start = 1'b0; A = 4'h0; shr = 2'd0; mode = 2'd0;
      chk({name, "_busy_e0"}, int'(busy), 1);
      chk({name, "_done_e0"}, int'(done), 0);
      n = 0;
      while (n < 10) begin
         cyc();
         n++;
         if (done) break;
      end
      chk({name, "_latency"}, n, exp_lat);
      chk({name, "_out"}, int'(OUT), int'(exp_out));
      cyc();
      chk({name, "_idle_done"}, int'(done), 0);
      chk({name, "_idle_busy"}, int'(busy), 0);
      chk({name, "_hold_out"}, int'(OUT), int'(exp_out));
   endtask

   initial begin
      int dones;
      int t;
      int first_t;
      int second_t;
      int third_t;
      checks = 0;
      errors = 0;
      rst = 1'b1; start = 1'b0; A = 4'h0; shr = 2'd0; mode = 2'd0;

      vecs[0] = '{4'hC, 2'd2, 2'b00, 4'h3, 3};
      vecs[1] = '{4'h9, 2'd1, 2'b01, 4'hC, 2};
      vecs[2] = '{4'h8, 2'd3, 2'b01, 4'hF, 4};
      vecs[3] = '{4'h3, 2'd2, 2'b10, 4'hC, 3};
      vecs[4] = '{4'h1, 2'd3, 2'b10, 4'h2, 4};
      vecs[5] = '{4'h5, 2'd0, 2'b00, 4'h5, 1};
      vecs[6] = '{4'hF, 2'd3, 2'b11, 4'h1, 4};

      @(negedge clk);
      cyc();
      chk("reset_out", int'(OUT), 0);
      chk("reset_busy", int'(busy), 0);
      chk("reset_done", int'(done), 0);
      rst = 1'b0;
      cyc();

      for (int i = 0; i < 7; i++) begin
         run_op(vecs[i].a, vecs[i].s, vecs[i].m, vecs[i].exp_out,
                vecs[i].exp_lat, $sformatf("vec%0d", i));
      end

      // Result holds while idle.
      run_op(4'hC, 2'd2, 2'b00, 4'h3, 3, "hold");
      dones = 0;
      for (int i = 0; i < 4; i++) begin
         cyc();
         if (done) dones++;
      end
      chk("hold_out_4cyc", int'(OUT), 3);
      chk("hold_no_done", dones, 0);

      // Start pulsed while busy is ignored.
      start = 1'b1; A = 4'hC; shr = 2'd3; mode = 2'b00;
      cyc();
      start = 1'b0;
      cyc();
      start = 1'b1; A = 4'h0; shr = 2'd0;
      cyc();
      start = 1'b0;
      dones = 0;
      for (int i = 0; i < 10; i++) begin
         if (done) begin
            dones++;
            chk("ignore_out", int'(OUT), 1);
         end
         cyc();
      end
      chk("ignore_done_count", dones, 1);
      chk("ignore_final_out", int'(OUT), 1);

      // Start held high: back-to-back operations every shr+3 cycles.
      start = 1'b1; A = 4'hC; shr = 2'd1; mode = 2'b00;
      first_t = -1; second_t = -1; third_t = -1;
      for (t = 0; t < 20; t++) begin
         cyc();
         if (done) begin
            chk($sformatf("b2b_out_t%0d", t), int'(OUT), 6);
            if (first_t < 0) first_t = t;
            else if (second_t < 0) second_t = t;
            else if (third_t < 0) third_t = t;
         end
      end
      start = 1'b0;
      chk("b2b_first_lat", first_t, 2);
      chk("b2b_interval1", second_t - first_t, 4);
      chk("b2b_interval2", third_t - second_t, 4);
      for (int i = 0; i < 6; i++) cyc();
      chk("b2b_idle", int'(busy), 0);

      // Reset mid-operation aborts with no done pulse.
      start = 1'b1; A = 4'hF; shr = 2'd3; mode = 2'b00;
      cyc();
      start = 1'b0;
      rst = 1'b1;
      cyc();
      chk("midrst_out", int'(OUT), 0);
      chk("midrst_busy", int'(busy), 0);
      chk("midrst_done", int'(done), 0);
      rst = 1'b0;
      dones = 0;
      for (int i = 0; i < 8; i++) begin
         cyc();
         if (done || busy) dones++;
      end
      chk("midrst_no_done", dones, 0);
      run_op(4'h6, 2'd1, 2'b00, 4'h3, 2, "after_rst");

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   // Absolute time limit so the run can never hang.
   initial begin
      #100000;
      $display("FAIL timeout got running expected finished");
      $fatal(1);
   end

endmodule
